// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter for the single-port data memory
//
// Purpose: shares one fixed-latency single-port memory between the CPU
// load/store path and the DMA/program-loader port. Each port uses a
// req/ack handshake. The controller runs IDLE -> ISSUE -> WAIT -> ACK.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request fields (held until cpu_ack)
//   cpu_ack, cpu_rdata          CPU one-cycle completion, last read result
//   dma_*                       DMA port, same rules as the CPU port
//   mem_en/we/addr/wdata        memory strobe and access fields
//   mem_rdata                   memory read data, valid MEM_LAT cycles after mem_en
//   busy                        high whenever the FSM is not in IDLE
//   owner                       current/last grantee (0 = CPU, 1 = DMA)
module data_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic              r_busy;

    logic              w_any_req;
    logic              w_grant_dma;

    // Under contention the port that did not own the last grant wins;
    // owner resets to DMA so the CPU takes the first contended grant.
    assign w_any_req   = cpu_req | dma_req;
    assign w_grant_dma = dma_req & (~cpu_req | ~r_owner);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_owner     <= 1'b1;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // The memory fields double as the latched request,
                        // so they are valid during ISSUE and hold afterwards.
                        r_owner     <= w_grant_dma;
                        r_mem_we    <= w_grant_dma ? dma_we    : cpu_we;
                        r_mem_addr  <= w_grant_dma ? dma_addr  : cpu_addr;
                        r_mem_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
                        r_mem_en    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_cnt    <= CNT_W'(MEM_LAT);
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        // Last wait cycle: mem_rdata is valid now.
                        if (!r_mem_we) begin
                            if (r_owner) r_dma_rdata <= mem_rdata;
                            else         r_cpu_rdata <= mem_rdata;
                        end
                        r_cpu_ack <= ~r_owner;
                        r_dma_ack <= r_owner;
                        r_state   <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    r_cpu_ack <= 1'b0;
                    r_dma_ack <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        busy, owner;

    int vectors = 0;
    int miscompares = 0;
    int dma_ack_cnt = 0;

    data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory model: 2-cycle read latency. Unwritten words return a fixed
    // pattern so reads have known, distinct values.
    logic [15:0] mem [0:255];
    bit          wr_valid [0:255];
    logic [15:0] p_data = 16'h0;

    function automatic logic [15:0] pattern(input logic [7:0] a);
        case (a)
            8'h10:   return 16'hBEEF;
            8'h01:   return 16'h1111;
            8'h02:   return 16'h2222;
            8'h03:   return 16'h3333;
            default: return {8'hA5, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:0]]      <= mem_wdata;
                wr_valid[mem_addr[7:0]] <= 1'b1;
            end
            p_data <= wr_valid[mem_addr[7:0]] ? mem[mem_addr[7:0]] : pattern(mem_addr[7:0]);
        end
        mem_rdata <= p_data;
        if (dma_ack) dma_ack_cnt <= dma_ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_en"},    {31'b0, mem_en},  32'h0);
        chk({tag, " mem_we"},    {31'b0, mem_we},  32'h0);
        chk({tag, " mem_addr"},  {16'b0, mem_addr},  32'h0);
        chk({tag, " mem_wdata"}, {16'b0, mem_wdata}, 32'h0);
        chk({tag, " cpu_ack"},   {31'b0, cpu_ack}, 32'h0);
        chk({tag, " dma_ack"},   {31'b0, dma_ack}, 32'h0);
        chk({tag, " cpu_rdata"}, {16'b0, cpu_rdata}, 32'h0);
        chk({tag, " dma_rdata"}, {16'b0, dma_rdata}, 32'h0);
        chk({tag, " busy"},      {31'b0, busy},    32'h0);
        chk({tag, " owner"},     {31'b0, owner},   32'h1);
    endtask

    // Wait (bounded) for an ack on either port; cyc counts cycles elapsed.
    task automatic wait_any(output int cyc, output logic got_cpu, output logic got_dma);
        cyc = 0; got_cpu = 1'b0; got_dma = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
            if (cpu_ack || dma_ack) begin
                got_cpu = cpu_ack;
                got_dma = dma_ack;
                break;
            end
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, " busy"},   {31'b0, busy},   32'h0);
            chk({tag, " mem_en"}, {31'b0, mem_en}, 32'h0);
        end
    endtask

    int   cyc;
    logic gc, gd;
    int   dma_snap;

    initial begin
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        tick();
        chk_reset_vals("por");
        tick();
        reset = 1'b1;
        idle_check("idle0", 4);

        // Single CPU read of 0x0010.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        tick();
        chk("rd issue mem_en", {31'b0, mem_en}, 32'h1);
        chk("rd issue mem_we", {31'b0, mem_we}, 32'h0);
        chk("rd issue addr",   {16'b0, mem_addr}, 32'h0010);
        chk("rd issue busy",   {31'b0, busy}, 32'h1);
        chk("rd issue owner",  {31'b0, owner}, 32'h0);
        wait_any(cyc, gc, gd);
        chk("rd ack latency", cyc, 32'd3);
        chk("rd ack cpu", {31'b0, gc}, 32'h1);
        chk("rd ack dma", {31'b0, gd}, 32'h0);
        chk("rd rdata", {16'b0, cpu_rdata}, 32'hBEEF);
        cpu_req = 0;
        tick();
        chk("rd ack pulse", {31'b0, cpu_ack}, 32'h0);
        tick();
        chk("rd rdata hold", {16'b0, cpu_rdata}, 32'hBEEF);

        // Single DMA write 0x1234 -> 0x0020.
        dma_req = 1; dma_we = 1; dma_addr = 16'h0020; dma_wdata = 16'h1234;
        tick();
        chk("wr issue mem_en",    {31'b0, mem_en}, 32'h1);
        chk("wr issue mem_we",    {31'b0, mem_we}, 32'h1);
        chk("wr issue mem_addr",  {16'b0, mem_addr}, 32'h0020);
        chk("wr issue mem_wdata", {16'b0, mem_wdata}, 32'h1234);
        chk("wr issue owner",     {31'b0, owner}, 32'h1);
        tick();
        chk("wr mem_en one cycle", {31'b0, mem_en}, 32'h0);
        chk("wr addr hold",        {16'b0, mem_addr}, 32'h0020);
        wait_any(cyc, gc, gd);
        chk("wr ack latency", cyc, 32'd2);
        chk("wr ack dma", {31'b0, gd}, 32'h1);
        chk("wr ack cpu", {31'b0, gc}, 32'h0);
        chk("wr dma_rdata unchanged", {16'b0, dma_rdata}, 32'h0);
        chk("wr cpu_rdata unchanged", {16'b0, cpu_rdata}, 32'hBEEF);
        dma_req = 0;
        tick();

        // DMA writes 0x00FF to 0x0040, then CPU reads it back.
        dma_req = 1; dma_we = 1; dma_addr = 16'h0040; dma_wdata = 16'h00FF;
        wait_any(cyc, gc, gd);
        chk("wr40 ack dma", {31'b0, gd}, 32'h1);
        dma_req = 0;
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        wait_any(cyc, gc, gd);
        chk("rd40 ack cpu", {31'b0, gc}, 32'h1);
        chk("rd40 rdata", {16'b0, cpu_rdata}, 32'h00FF);
        cpu_req = 0;
        tick();

        // Back-to-back CPU reads with req held high.
        dma_snap = dma_ack_cnt;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
        wait_any(cyc, gc, gd);
        chk("b2b1 latency", cyc, 32'd4);
        chk("b2b1 rdata", {16'b0, cpu_rdata}, 32'h1111);
        cpu_addr = 16'h0002;
        wait_any(cyc, gc, gd);
        chk("b2b2 spacing", cyc, 32'd5);
        chk("b2b2 cpu", {31'b0, gc}, 32'h1);
        chk("b2b2 rdata", {16'b0, cpu_rdata}, 32'h2222);
        cpu_addr = 16'h0003;
        wait_any(cyc, gc, gd);
        chk("b2b3 spacing", cyc, 32'd5);
        chk("b2b3 cpu", {31'b0, gc}, 32'h1);
        chk("b2b3 rdata", {16'b0, cpu_rdata}, 32'h3333);
        cpu_req = 0;
        tick();
        chk("b2b no dma ack", dma_ack_cnt - dma_snap, 32'd0);

        // Asynchronous reset in the middle of WAIT.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002;
        tick();
        tick();
        chk("mid busy before reset", {31'b0, busy}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        cpu_req = 0;
        tick();
        chk("held reset no ack", {31'b0, cpu_ack}, 32'h0);
        tick();
        reset = 1'b1;
        idle_check("idle1", 4);

        // Contention from reset: CPU, DMA, CPU, DMA.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
        wait_any(cyc, gc, gd);
        chk("ct1 latency", cyc, 32'd4);
        chk("ct1 cpu", {31'b0, gc}, 32'h1);
        chk("ct1 owner", {31'b0, owner}, 32'h0);
        chk("ct1 rdata", {16'b0, cpu_rdata}, 32'hBEEF);
        wait_any(cyc, gc, gd);
        chk("ct2 spacing", cyc, 32'd5);
        chk("ct2 dma", {31'b0, gd}, 32'h1);
        chk("ct2 owner", {31'b0, owner}, 32'h1);
        chk("ct2 rdata", {16'b0, dma_rdata}, 32'h1234);
        wait_any(cyc, gc, gd);
        chk("ct3 spacing", cyc, 32'd5);
        chk("ct3 cpu", {31'b0, gc}, 32'h1);
        chk("ct3 owner", {31'b0, owner}, 32'h0);
        wait_any(cyc, gc, gd);
        chk("ct4 spacing", cyc, 32'd5);
        chk("ct4 dma", {31'b0, gd}, 32'h1);
        chk("ct4 owner", {31'b0, owner}, 32'h1);
        cpu_req = 0; dma_req = 0;
        idle_check("idle2", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
